// File: rtl/rx_frame_parser.sv
// rx_frame_parser: hunts for SYNC_BYTE, collects a length-prefixed XOR-checked payload, replays it on valid/ready.
// Define RX_FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle clocks.
module rx_frame_parser #(
   parameter int         MAX_LEN        = 16,
   parameter logic [7:0] SYNC_BYTE      = 8'hAA,
   parameter int         TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rxData,
   input  logic       rxDone,
   output logic [7:0] outData,
   output logic       outValid,
   output logic       outLast,
   input  logic       outReady,
   output logic       frameError,
   output logic       dropByte,
   output logic       busy
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CSUM, S_OUT} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_rx_done_d;
   logic          w_strobe;
   logic [7:0]    r_buf [2**AW];
   logic [7:0]    r_csum, w_csum_nxt;
   logic [LW-1:0] r_len, r_idx, r_rd_idx;
   logic [LW-1:0] w_len_nxt, w_idx_nxt, w_rd_idx_nxt, w_len_m1;
   logic          w_wr, w_err, w_timeout, w_out_nxt;

   assign w_strobe  = rxDone & ~r_rx_done_d;
   assign w_len_m1  = r_len - LW'(1);
   assign w_out_nxt = (w_state_nxt == S_OUT);

`ifdef RX_FRAME_TIMEOUT_EN
   logic [15:0] r_gap;
   logic        w_gap_run;
   assign w_gap_run = r_state inside {S_LEN, S_PAYLOAD, S_CSUM};
   assign w_timeout = w_gap_run & ~w_strobe & (r_gap + 16'd1 == 16'(TIMEOUT_CYCLES));
   always_ff @(posedge clk)
      if (!rst || !w_gap_run || w_strobe || w_timeout) r_gap <= '0;
      else r_gap <= r_gap + 16'd1;
`else
   assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_len_nxt    = r_len;
      w_csum_nxt   = r_csum;
      w_idx_nxt    = r_idx;
      w_rd_idx_nxt = r_rd_idx;
      w_wr         = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         S_SYNC:
            if (w_strobe && rxData == SYNC_BYTE) w_state_nxt = S_LEN;
         S_LEN:
            if (w_strobe) begin
               if (rxData == 8'd0 || 32'(rxData) > MAX_LEN) begin
                  w_err       = 1'b1;
                  w_state_nxt = S_SYNC;
               end else begin
                  w_len_nxt   = rxData[LW-1:0];
                  w_csum_nxt  = rxData;
                  w_idx_nxt   = '0;
                  w_state_nxt = S_PAYLOAD;
               end
            end
         S_PAYLOAD:
            if (w_strobe) begin
               w_wr        = 1'b1;
               w_csum_nxt  = r_csum ^ rxData;
               w_idx_nxt   = r_idx + LW'(1);
               w_state_nxt = (r_idx == w_len_m1) ? S_CSUM : S_PAYLOAD;
            end
         S_CSUM:
            if (w_strobe) begin
               w_err        = (rxData != r_csum);
               w_rd_idx_nxt = '0;
               w_state_nxt  = (rxData == r_csum) ? S_OUT : S_SYNC;
            end
         S_OUT:
            if (outValid && outReady) begin
               w_rd_idx_nxt = r_rd_idx + LW'(1);
               w_state_nxt  = outLast ? S_SYNC : S_OUT;
            end
         default: w_state_nxt = S_SYNC;
      endcase
      if (w_timeout) begin
         w_err       = 1'b1;
         w_state_nxt = S_SYNC;
      end
   end

   // Payload storage is never reset; every read follows a write in the same frame.
   always_ff @(posedge clk)
      if (w_wr) r_buf[r_idx[AW-1:0]] <= rxData;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_SYNC;
         r_rx_done_d <= 1'b1;
         r_csum      <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_rd_idx    <= '0;
         outData     <= '0;
         outValid    <= 1'b0;
         outLast     <= 1'b0;
         frameError  <= 1'b0;
         dropByte    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rx_done_d <= rxDone;
         r_csum      <= w_csum_nxt;
         r_len       <= w_len_nxt;
         r_idx       <= w_idx_nxt;
         r_rd_idx    <= w_rd_idx_nxt;
         outValid    <= w_out_nxt;
         outData     <= w_out_nxt ? r_buf[w_rd_idx_nxt[AW-1:0]] : 8'd0;
         outLast     <= w_out_nxt && (w_rd_idx_nxt == w_len_m1);
         frameError  <= w_err;
         dropByte    <= w_strobe && (r_state == S_OUT);
         busy        <= (w_state_nxt != S_SYNC);
      end
   end
endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: directed and randomized frames checked against a queue-based frame model.
module tb_rx_frame_parser;
   localparam int MAX_LEN = 16;
   localparam int TO      = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rxData = 8'hAA;
   logic       rxDone = 1'b1;
   logic       outReady = 1'b0;
   logic [7:0] outData;
   logic       outValid, outLast, frameError, dropByte, busy;

   int checks = 0;
   int failures = 0;
   logic [8:0] cap_q[$];
   logic [7:0] tx_q[$];
   int ferr_cnt = 0, drop_cnt = 0, idle_bad = 0;

   rx_frame_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .rxData(rxData), .rxDone(rxDone),
      .outData(outData), .outValid(outValid), .outLast(outLast), .outReady(outReady),
      .frameError(frameError), .dropByte(dropByte), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (outValid && outReady) cap_q.push_back({outLast, outData});
      if (frameError) ferr_cnt++;
      if (dropByte) drop_cnt++;
      if (!outValid && outData !== 8'd0) idle_bad++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   // Leaves rxDone high just after the strobe edge so callers can check the following cycle.
   task automatic strobe_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rxDone = 1'b0;
      @(posedge clk); #1;
      rxData = b;
      rxDone = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_all();
      while (tx_q.size() > 0) strobe_byte(tx_q.pop_front());
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({outData, outValid, outLast, frameError, dropByte, busy} !== 13'd0) begin
         failures++;
         $display("FAIL reset_outputs: got d=%h v=%b l=%b fe=%b db=%b busy=%b, want all 0",
                  outData, outValid, outLast, frameError, dropByte, busy);
      end
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_strobe: got busy=%b, want 0", busy);
      end
   endtask

   task automatic test_good_frame();
      logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
      int e0 = ferr_cnt;
      cap_q.delete();
      outReady = 1'b1;
      tx_q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33};
      send_all();
      strobe_byte(8'h03);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({outValid, outLast, outData} !== {1'b1, 1'(i == 2), d[i]}) begin
            failures++;
            $display("FAIL good_byte%0d: got v=%b l=%b d=%h, want v=1 l=%b d=%h",
                     i, outValid, outLast, outData, i == 2, d[i]);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (outValid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL good_end: got v=%b busy=%b, want 0 0", outValid, busy);
      end
      checks++;
      if (ferr_cnt != e0) begin
         failures++;
         $display("FAIL good_no_error: got %0d errors, want 0", ferr_cnt - e0);
      end
   endtask

   task automatic test_leading_garbage();
      int e0 = ferr_cnt;
      cap_q.delete();
      outReady = 1'b1;
      tx_q = '{8'h55, 8'hAA, 8'h01, 8'h7E};
      send_all();
      strobe_byte(8'h7F);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cap_q.size() != 1 || cap_q[0] !== {1'b1, 8'h7E}) begin
         failures++;
         $display("FAIL garbage_output: got %0d bytes first=%h, want 1 byte 17e",
                  cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 9'h0);
      end
      checks++;
      if (ferr_cnt != e0) begin
         failures++;
         $display("FAIL garbage_no_error: got %0d errors, want 0", ferr_cnt - e0);
      end
   endtask

   task automatic test_bad_frames();
      int e0 = ferr_cnt;
      cap_q.delete();
      outReady = 1'b1;
      strobe_byte(8'hAA);
      strobe_byte(8'h11);
      checks++;
      if (frameError !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bad_len: got fe=%b busy=%b, want 1 0", frameError, busy);
      end
      tx_q = '{8'hAA, 8'h02, 8'h10, 8'h20};
      send_all();
      strobe_byte(8'h00);
      checks++;
      if (frameError !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bad_csum: got fe=%b busy=%b, want 1 0", frameError, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cap_q.size() != 0 || ferr_cnt != e0 + 2) begin
         failures++;
         $display("FAIL bad_summary: got %0d bytes %0d error cycles, want 0 bytes 2 error cycles",
                  cap_q.size(), ferr_cnt - e0);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
      int d0 = drop_cnt;
      cap_q.delete();
      outReady = 1'b0;
      tx_q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33};
      send_all();
      strobe_byte(8'h03);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({outValid, outLast, outData} !== {1'b1, 1'b0, 8'h11}) begin
            failures++;
            $display("FAIL stall_cycle%0d: got v=%b l=%b d=%h, want v=1 l=0 d=11",
                     i, outValid, outLast, outData);
         end
         @(posedge clk); #1;
      end
      strobe_byte(8'h5A);
      checks++;
      if (dropByte !== 1'b1 || outValid !== 1'b1 || outData !== 8'h11) begin
         failures++;
         $display("FAIL overrun: got db=%b v=%b d=%h, want db=1 v=1 d=11", dropByte, outValid, outData);
      end
      outReady = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (cap_q.size() != 3) begin
         failures++;
         $display("FAIL bp_count: got %0d bytes, want 3", cap_q.size());
      end
      for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== {1'(i == 2), d[i]}) begin
            failures++;
            $display("FAIL bp_byte%0d: got %h, want %h", i, cap_q[i], {1'(i == 2), d[i]});
         end
      end
      checks++;
      if (drop_cnt != d0 + 1) begin
         failures++;
         $display("FAIL bp_drop_count: got %0d, want 1", drop_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e[3] = '{9'h142, 9'h00A, 9'h10B};
      cap_q.delete();
      outReady = 1'b1;
      tx_q = '{8'hAA, 8'h01, 8'h42};
      send_all();
      strobe_byte(8'h43);
      rxDone = 1'b0;
      @(posedge clk); #1;
      rxData = 8'hAA;
      rxDone = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || outValid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_sync: got busy=%b v=%b, want busy=1 v=0", busy, outValid);
      end
      tx_q = '{8'h02, 8'h0A, 8'h0B};
      send_all();
      strobe_byte(8'h03);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (cap_q.size() != 3) begin
         failures++;
         $display("FAIL b2b_count: got %0d bytes, want 3", cap_q.size());
      end
      for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== e[i]) begin
            failures++;
            $display("FAIL b2b_byte%0d: got %h, want %h", i, cap_q[i], e[i]);
         end
      end
   endtask

   task automatic test_random_frames();
      logic [8:0] exp_q[$];
      logic [7:0] b, cs;
      int e0 = ferr_cnt, d0 = drop_cnt, i0 = idle_bad, exp_err = 0;
      int len, kind, n;
      cap_q.delete();
      for (int f = 0; f < 24; f++) begin
         for (int g = 0; g < int'($urandom % 3); g++) begin
            b = 8'($urandom);
            tx_q.push_back(b == 8'hAA ? 8'h55 : b);
         end
         tx_q.push_back(8'hAA);
         kind = int'($urandom % 5);
         if (kind == 0) begin
            len = ($urandom % 2) ? 0 : MAX_LEN + 1 + int'($urandom % (255 - MAX_LEN));
            tx_q.push_back(8'(len));
            exp_err++;
         end else begin
            len = 1 + int'($urandom % MAX_LEN);
            cs = 8'(len);
            tx_q.push_back(8'(len));
            for (int p = 0; p < len; p++) begin
               b = 8'($urandom);
               tx_q.push_back(b);
               cs ^= b;
               if (kind != 1) exp_q.push_back({1'(p == len - 1), b});
            end
            if (kind == 1) begin
               tx_q.push_back(cs ^ 8'(1 + $urandom % 255));
               exp_err++;
            end else tx_q.push_back(cs);
         end
         outReady = 1'b1;
         send_all();
         n = 0;
         while (busy && n < 1000) begin
            @(posedge clk); #1;
            outReady = 1'($urandom % 2);
            n++;
         end
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rnd_drain%0d: got busy=%b after %0d cycles, want 0", f, busy, n);
         end
      end
      outReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cap_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rnd_count: got %0d bytes, want %0d", cap_q.size(), exp_q.size());
      end
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rnd_byte%0d: got %h, want %h", i, cap_q[i], exp_q[i]);
         end
      end
      checks++;
      if (ferr_cnt - e0 != exp_err || drop_cnt != d0 || idle_bad != i0) begin
         failures++;
         $display("FAIL rnd_events: got errors=%0d drops=%0d idle_nonzero=%0d, want %0d 0 0",
                  ferr_cnt - e0, drop_cnt - d0, idle_bad - i0, exp_err);
      end
   endtask

   task automatic test_reset_mid();
      int e0;
      cap_q.delete();
      tx_q = '{8'hAA, 8'h05, 8'h01};
      send_all();
      strobe_byte(8'h02);
      e0 = ferr_cnt;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({outData, outValid, outLast, frameError, dropByte, busy} !== 13'd0) begin
         failures++;
         $display("FAIL rst_payload: got d=%h v=%b l=%b fe=%b db=%b busy=%b, want all 0",
                  outData, outValid, outLast, frameError, dropByte, busy);
      end
      rst = 1'b1;
      outReady = 1'b0;
      tx_q = '{8'hAA, 8'h01, 8'h42};
      send_all();
      strobe_byte(8'h43);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({outData, outValid, outLast, busy} !== 11'd0) begin
         failures++;
         $display("FAIL rst_output: got d=%h v=%b l=%b busy=%b, want all 0", outData, outValid, outLast, busy);
      end
      rst = 1'b1;
      outReady = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || cap_q.size() != 0 || ferr_cnt != e0) begin
         failures++;
         $display("FAIL rst_after: got busy=%b bytes=%0d errors=%0d, want 0 0 0",
                  busy, cap_q.size(), ferr_cnt - e0);
      end
   endtask

   task automatic test_timeout();
      int k;
      tx_q = '{8'hAA, 8'h04};
      send_all();
      strobe_byte(8'h01);
`ifdef RX_FRAME_TIMEOUT_EN
      k = 1;
      while (k <= 150) begin
         @(posedge clk); #1;
         if (frameError) break;
         k++;
      end
      checks++;
      if (k != TO || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout: got error after %0d cycles busy=%b, want %0d cycles busy=0", k, busy, TO);
      end
`else
      k = 0;
      repeat (3 * TO) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || frameError !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout: got busy=%b fe=%b, want busy=1 fe=0", busy, frameError);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
`endif
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_leading_garbage();
      test_bad_frames();
      test_backpressure();
      test_back_to_back();
      test_random_frames();
      test_reset_mid();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
